pong_game_ctrl: RTL

- Frame-rate game controller for the Pong display.
- Consumes the 640x480 sync counter outputs (pixel_x, pixel_y, p_tick) and derives a once-per-frame refresh strobe.
- On each strobe it updates the paddle and ball positions, resolves collisions, keeps score and lives, and sequences the game through a four-state FSM.
- Outputs are object coordinates and status, consumed by the pixel renderer.

---
 rtl/pong_pkg.sv | 29 ++
 rtl/pong_game_ctrl_if.sv | 38 +++
 rtl/pong_bcd_counter.sv | 30 +++
 rtl/pong_game_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// pong_pkg: game states and screen geometry shared by
// the game controller and the pixel renderer.
package pong_pkg;

   typedef enum logic [1:0] {
      NEWGAME = 2'd0,
      PLAY    = 2'd1,
      NEWBALL = 2'd2,
      OVER    = 2'd3
   } game_state_t;

   localparam int H_DISPLAY   = 640;
   localparam int V_DISPLAY   = 480;
   localparam int WALL_X_R    = 35;
   localparam int BAR_X_L     = 600;
   localparam int BAR_X_R     = 603;
   localparam int BAR_H       = 72;
   localparam int BALL_SIZE   = 8;
   localparam int PAD_V       = 4;
   localparam int BALL_V      = 2;
   localparam int LIVES       = 3;
   localparam int WAIT_FRAMES = 120;

   localparam logic [9:0] BAR_Y_RST  = 10'((V_DISPLAY - BAR_H) / 2);
   localparam logic [9:0] BALL_X_RST = 10'((H_DISPLAY - BALL_SIZE) / 2);
   localparam logic [9:0] BALL_Y_RST = 10'((V_DISPLAY - BALL_SIZE) / 2);
   localparam logic [9:0] REFR_Y     = 10'(V_DISPLAY + 1);

endpackage

// File: rtl/pong_game_ctrl_if.sv
// pong_game_ctrl_if: sync counter and button inputs in,
// object coordinates and game status out.
interface pong_game_ctrl_if;

   logic [9:0] pixel_x;
   logic [9:0] pixel_y;
   logic       p_tick;
   logic       btn_up;
   logic       btn_down;
   logic       btn_start;
   logic       refr_tick;
   logic [9:0] bar_y_t;
   logic [9:0] ball_x;
   logic [9:0] ball_y;
   logic       ball_on;
   logic [7:0] score;
   logic [1:0] lives;
   logic [1:0] game_state;
   logic       hit;
   logic       miss;

   modport master (
      output pixel_x, pixel_y, p_tick,
      output btn_up, btn_down, btn_start,
      input  refr_tick, bar_y_t, ball_x, ball_y,
      input  ball_on, score, lives, game_state,
      input  hit, miss
   );

   modport slave (
      input  pixel_x, pixel_y, p_tick,
      input  btn_up, btn_down, btn_start,
      output refr_tick, bar_y_t, ball_x, ball_y,
      output ball_on, score, lives, game_state,
      output hit, miss
   );

endinterface

// File: rtl/pong_bcd_counter.sv
// pong_bcd_counter: two-digit BCD counter, synchronous
// clear over increment, wraps 99 -> 00.
module pong_bcd_counter (
   input  logic       clk,
   input  logic       reset,
   input  logic       clr,
   input  logic       inc,
   output logic [7:0] count
);

   // digit-wise increment with carry from ones into tens
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= 8'h00;
      end else if (clr) begin
         count <= 8'h00;
      end else if (inc) begin
         if (count[3:0] == 4'd9) begin
            count[3:0] <= 4'd0;
            if (count[7:4] == 4'd9)
               count[7:4] <= 4'd0;
            else
               count[7:4] <= count[7:4] + 4'd1;
         end else begin
            count[3:0] <= count[3:0] + 4'd1;
         end
      end
   end

endmodule

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: per-frame paddle/ball update, collisions, score, lives.
// Build option PONG_ATTRACT_EN: ball and paddle self-play in NEWGAME.
module pong_game_ctrl
   import pong_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   pong_game_ctrl_if.slave bus
);

   localparam logic signed [10:0] DV    = 11'(BALL_V);
   localparam logic signed [10:0] B7    = 11'(BALL_SIZE - 1);
   localparam logic signed [10:0] B8    = 11'(BALL_SIZE);
   localparam logic signed [10:0] BH1   = 11'(BAR_H - 1);
   localparam logic signed [10:0] X_MAX = 11'(H_DISPLAY - 1);
   localparam logic signed [10:0] XL    = 11'(BAR_X_L);
   localparam logic signed [10:0] XR    = 11'(BAR_X_R);
   localparam logic signed [10:0] XW    = 11'(WALL_X_R);
   localparam logic signed [10:0] Y_TOP = 11'sd1;
   localparam logic signed [10:0] Y_BOT = 11'(V_DISPLAY - 2);

   game_state_t state, state_n;

   logic        refr;
   logic [9:0]  bar_q, bar_n, pad_y;
   logic [9:0]  bx_q, bx_n, by_q, by_n;
   logic        vx_q, vx_n, vy_q, vy_n;
   logic        vx_b, vy_b;
   logic        on_q, on_n;
   logic [1:0]  lives_q, lives_n;
   logic [6:0]  timer_q, timer_n;
   logic        hit_q, hit_n, miss_q, miss_n;
   logic        sc_clr, sc_inc;
   logic [7:0]  score_q;
   logic        up_ok, dn_ok;
   logic        is_miss, is_hit;
   logic signed [10:0] nx, ny, ed, bar_s;

   assign refr = bus.p_tick && (bus.pixel_x == 10'd0)
              && (bus.pixel_y == REFR_Y);

   // candidate ball position and the collisions it produces
   always_comb begin
      nx      = $signed({1'b0, bx_q}) + (vx_q ? -DV : DV);
      ny      = $signed({1'b0, by_q}) + (vy_q ? -DV : DV);
      ed      = nx + B7;
      bar_s   = $signed({1'b0, bar_q});
      is_miss = ed > X_MAX;
      is_hit  = (ed >= XL) && (ed <= XR)
             && (ny <= bar_s + BH1) && (ny + B7 >= bar_s);
      vx_b    = vx_q;
      vy_b    = vy_q;
      if (is_hit)
         vx_b = 1'b1;
      else if (nx <= XW)
         vx_b = 1'b0;
      if (ny <= Y_TOP)
         vy_b = 1'b0;
      else if (ny + B8 >= Y_BOT)
         vy_b = 1'b1;
   end

   // button-driven paddle step, clamped to the screen
   always_comb begin
      up_ok = bar_q >= 10'(PAD_V);
      dn_ok = ({1'b0, bar_q} + 11'(BAR_H + PAD_V))
           <= 11'(V_DISPLAY - 1);
      pad_y = bar_q;
      unique case (1'b1)
         (bus.btn_up && !bus.btn_down && up_ok):
            pad_y = bar_q - 10'(PAD_V);
         (bus.btn_down && !bus.btn_up && dn_ok):
            pad_y = bar_q + 10'(PAD_V);
         default:
            pad_y = bar_q;
      endcase
   end

`ifdef PONG_ATTRACT_EN
   logic [9:0]  track_y;
   logic [10:0] c_ball, c_bar;

   // attract mode: paddle chases the ball's vertical centre
   always_comb begin
      c_ball  = {1'b0, by_q} + 11'(BALL_SIZE / 2);
      c_bar   = {1'b0, bar_q} + 11'(BAR_H / 2);
      track_y = bar_q;
      if (c_ball < c_bar && up_ok)
         track_y = bar_q - 10'(PAD_V);
      else if (c_ball > c_bar && dn_ok)
         track_y = bar_q + 10'(PAD_V);
   end
`endif

   // game state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= NEWGAME;
      else
         state <= state_n;
   end

   // next state and next object/status values, once per frame
   always_comb begin
      state_n = state;
      bar_n   = bar_q;
      bx_n    = bx_q;
      by_n    = by_q;
      vx_n    = vx_q;
      vy_n    = vy_q;
      on_n    = on_q;
      lives_n = lives_q;
      timer_n = timer_q;
      hit_n   = 1'b0;
      miss_n  = 1'b0;
      sc_clr  = 1'b0;
      sc_inc  = 1'b0;
      if (refr) begin
         unique case (state)
            NEWGAME: begin
               lives_n = 2'(LIVES);
               sc_clr  = 1'b1;
               on_n    = 1'b0;
`ifdef PONG_ATTRACT_EN
               on_n  = 1'b1;
               bar_n = track_y;
               if (is_miss) begin
                  bx_n = BALL_X_RST;
                  by_n = BALL_Y_RST;
                  vx_n = 1'b1;
                  vy_n = 1'b0;
               end else begin
                  bx_n = nx[9:0];
                  by_n = ny[9:0];
                  vx_n = vx_b;
                  vy_n = vy_b;
               end
`endif
               if (bus.btn_start) begin
                  state_n = PLAY;
                  on_n    = 1'b1;
                  bx_n    = BALL_X_RST;
                  by_n    = BALL_Y_RST;
                  vx_n    = 1'b1;
                  vy_n    = 1'b0;
               end
            end
            PLAY: begin
               bar_n = pad_y;
               bx_n  = nx[9:0];
               by_n  = ny[9:0];
               if (is_miss) begin
                  miss_n  = 1'b1;
                  on_n    = 1'b0;
                  timer_n = 7'(WAIT_FRAMES);
                  lives_n = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
                  state_n = (lives_q <= 2'd1) ? OVER : NEWBALL;
               end else begin
                  vx_n   = vx_b;
                  vy_n   = vy_b;
                  hit_n  = is_hit;
                  sc_inc = is_hit;
               end
            end
            NEWBALL: begin
               bar_n = pad_y;
               if (timer_q <= 7'd1) begin
                  timer_n = 7'd0;
                  state_n = PLAY;
                  on_n    = 1'b1;
                  bx_n    = BALL_X_RST;
                  by_n    = BALL_Y_RST;
                  vx_n    = 1'b1;
                  vy_n    = 1'b0;
               end else begin
                  timer_n = timer_q - 7'd1;
               end
            end
            OVER: begin
               if (timer_q <= 7'd1) begin
                  timer_n = 7'd0;
                  state_n = NEWGAME;
                  lives_n = 2'(LIVES);
                  sc_clr  = 1'b1;
               end else begin
                  timer_n = timer_q - 7'd1;
               end
            end
            default: state_n = NEWGAME;
         endcase
      end
   end

   // object, velocity, lives, timer and event registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bar_q   <= BAR_Y_RST;
         bx_q    <= BALL_X_RST;
         by_q    <= BALL_Y_RST;
         vx_q    <= 1'b1;
         vy_q    <= 1'b0;
         on_q    <= 1'b0;
         lives_q <= 2'(LIVES);
         timer_q <= 7'd0;
         hit_q   <= 1'b0;
         miss_q  <= 1'b0;
      end else begin
         bar_q   <= bar_n;
         bx_q    <= bx_n;
         by_q    <= by_n;
         vx_q    <= vx_n;
         vy_q    <= vy_n;
         on_q    <= on_n;
         lives_q <= lives_n;
         timer_q <= timer_n;
         hit_q   <= hit_n;
         miss_q  <= miss_n;
      end
   end

   pong_bcd_counter u_score (
      .clk   (clk),
      .reset (reset),
      .clr   (sc_clr),
      .inc   (sc_inc),
      .count (score_q)
   );

   assign bus.refr_tick  = refr;
   assign bus.bar_y_t    = bar_q;
   assign bus.ball_x     = bx_q;
   assign bus.ball_y     = by_q;
   assign bus.ball_on    = on_q;
   assign bus.score      = score_q;
   assign bus.lives      = lives_q;
   assign bus.game_state = state;
   assign bus.hit        = hit_q;
   assign bus.miss       = miss_q;

endmodule
